anton_product_driver: RTL and testbench
=======================================

Name: anton_product_driver

Overview:
Host-side initiator for the nibble-serial product unit.
- Accepts a pair of 4-bit operands over a valid/ready request port.
- Shifts them into the unit as two nibbles, then pulses the unit's read line.
- Captures the 8-bit product from the unit's output and returns it over a valid/ready response port.
- Optional self-check compares the captured product against a locally computed A*B.
- Lives on the same clock as the product unit, in test harnesses and on-chip sequencers.

Parameters:
LAT, 1, cycles from the edge that registers read=1 to the edge that samples p_result; allowed range 1..4. LAT=1 means a direct connection; each extra output-path register adds 1.
CHECK, 1, 1 = enable the internal A*B compare and the err flag; 0 = err tied 0 and the compare logic removed.

Ports:
clk  input  1  single clock, shared with the product unit
reset  input  1  synchronous, active-high
req_valid  input  1  operand request valid
req_ready  output  1  high only in IDLE
req_a  input  4  first operand (high nibble)
req_b  input  4  second operand (low nibble)
res_valid  output  1  product available
res_ready  input  1  consumer accepts product
res_product  output  8  captured product
err  output  1  sticky mismatch flag (CHECK=1 only)
p_reset  output  1  drives the unit's reset line
p_read  output  1  drives the unit's read line
p_nibble  output  4  drives the unit's nibble bus
p_result  input  8  unit's 8-bit output

Behaviour:
- Reset (sync): state=INIT; res_valid=0, res_product=0, err=0, p_read=0, p_nibble=0, p_reset=0 on the cycle after reset is sampled. Reset mid-transaction aborts it; no partial result is emitted.
- INIT: p_reset=1 for exactly one cycle, then IDLE. This clears the unit.
- IDLE: req_ready=1; p_read=0, p_nibble=0. The unit shifts zeros, which is harmless. On req_valid&req_ready, latch A=req_a and B=req_b, then go to SEND_A.
- SEND_A (1 cycle): p_nibble=A, p_read=0. Next state SEND_B.
- SEND_B (1 cycle): p_nibble=B, p_read=0. After this edge the unit holds {A,B}. Next state READ.
- READ (1 cycle): p_read=1, p_nibble=0. Load wait counter with LAT-1. Next state WAIT.
- WAIT: p_read=0, p_nibble=0.
  - Counter nonzero: decrement.
  - Counter zero: at that edge, res_product<=p_result, res_valid<=1, go to DONE.
  - Net effect: p_result is sampled exactly LAT edges after the READ edge. The unit's internal value is overwritten by later shifting; only the pipelined copy is sampled.
- CHECK=1: at the capture edge, err<=err|(p_result != A*B). The compare is an 8-bit unsigned product of the zero-extended nibbles. err stays set until reset.
- DONE: res_valid=1 and res_product held stable until res_ready. On res_valid&res_ready, res_valid<=0 and go to IDLE.
  - req_ready=0 throughout; requests presented meanwhile are not accepted.
  - A new request is accepted no earlier than the cycle after the handshake, because IDLE is entered first.
- Fixed sequence of 4+LAT cycles from request acceptance to res_valid. No pipelining; at most one transaction in flight.
- Arithmetic: max product 15*15=225 fits 8 bits; no overflow path.
- p_reset is asserted only in INIT. p_read is never high in the same cycle as a non-zero p_nibble.

Test Plan:
- Reset, then one cycle of p_reset=1, then req_ready=1. Check res_valid=0, err=0, p_nibble=0, p_read=0.
- LAT=1 with a behavioural unit model, A=3, B=5:
  - p_nibble shows 3 then 5, then p_read=1 for one cycle.
  - res_valid rises 5 cycles after acceptance with res_product=15 (0x0F); err=0.
- A=15, B=15 -> 225 (0xE1). A=0, B=9 -> 0. A=1, B=1 -> 1.
- LAT=3 with two extra output registers, A=7, B=6: res_product=42 sampled at the 3rd edge after the READ edge.
  - Negative check: with the model wired at LAT=1 but parameter LAT=3, err asserts and stays 1.
- Backpressure: hold res_ready=0 for 10 cycles with req_valid held high and new operands.
  - res_product stays stable and req_ready=0.
  - After res_ready=1, the next transaction starts from IDLE.
- Assert reset during SEND_B: no res_valid, INIT is re-entered with its one p_reset pulse, and the next transaction A=2, B=4 -> 8 is correct.

Source files
------------

// File: rtl/anton_product_driver.sv
// anton_product_driver
//
// Host-side initiator for the nibble-serial product unit. An operand pair
// accepted on the request port is shifted into the unit as two nibbles
// (A, then B). The driver then pulses the unit's read line and waits LAT edges
// before sampling the 8-bit product. The product is returned on the response
// port. With CHECK=1 the captured product is also compared against a locally
// computed A*B, and any mismatch sets a sticky err flag.
//
// Ports:
//   clk          in   clock shared with the product unit
//   reset        in   synchronous, active-high
//   req_valid    in   operand request valid
//   req_ready    out  high only while idle
//   req_a        in   first operand (shifted first, high nibble)
//   req_b        in   second operand (low nibble)
//   res_valid    out  product available
//   res_ready    in   consumer accepts product
//   res_product  out  captured product
//   err          out  sticky self-check mismatch (0 when CHECK=0)
//   p_reset      out  unit reset line
//   p_read       out  unit read line
//   p_nibble     out  unit nibble bus
//   p_result     in   unit 8-bit result (after LAT-1 output registers)

module anton_product_driver #(
    parameter int unsigned LAT   = 1,
    parameter bit          CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_product,
    output logic       err,
    output logic       p_reset,
    output logic       p_read,
    output logic [3:0] p_nibble,
    input  logic [7:0] p_result
);

    localparam int unsigned CntW = 2;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StSendA,
        StSendB,
        StRead,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_product_q, res_product_d;
    logic            p_reset_q, p_reset_d;
    logic            capture;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        p_reset_d     = 1'b0;
        capture       = 1'b0;

        case (state_q)
            // p_reset is a flop that is cleared by reset. INIT therefore spends
            // one cycle with p_reset low and one cycle with it high, then
            // moves to IDLE. The unit sees exactly one clearing pulse.
            StInit: begin
                p_reset_d = ~p_reset_q;
                if (p_reset_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = StSendA;
                end
            end
            StSendA: state_d = StSendB;
            StSendB: state_d = StRead;
            StRead: begin
                cnt_d   = CntW'(LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture       = 1'b1;
                    res_product_d = p_result;
                    res_valid_d   = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StInit;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            p_reset_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            p_reset_q     <= p_reset_d;
        end
    end

    // Unit-side outputs decode straight from the state flops. Outside the two
    // send states the nibble bus is zero, so a read pulse never coincides with
    // a non-zero nibble.
    always_comb begin
        p_nibble = 4'h0;
        case (state_q)
            StSendA: p_nibble = a_q;
            StSendB: p_nibble = b_q;
            default: p_nibble = 4'h0;
        endcase
    end

    assign p_read      = (state_q == StRead);
    assign p_reset     = p_reset_q;
    assign req_ready   = (state_q == StIdle);
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;

    if (CHECK) begin : g_check
        logic       err_q;
        logic [7:0] expect_prod;

        assign expect_prod = {4'b0, a_q} * {4'b0, b_q};

        always_ff @(posedge clk) begin
            if (reset) begin
                err_q <= 1'b0;
            end else if (capture && (p_result != expect_prod)) begin
                err_q <= 1'b1;
            end
        end

        assign err = err_q;
    end else begin : g_no_check
        assign err = 1'b0;
    end

endmodule

// File: tb/tb_anton_product_driver.sv
// Testbench for anton_product_driver. It drives three lanes, each with its own
// driver and behavioural product unit:
//   lane 0: LAT=1 driver, unit connected directly
//   lane 1: LAT=3 driver, unit followed by two extra output registers
//   lane 2: LAT=3 driver, unit connected directly (mis-wired, so err must rise)
module tb_anton_product_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid [3];
    logic       req_ready [3];
    logic [3:0] req_a [3];
    logic [3:0] req_b [3];
    logic       res_valid [3];
    logic       res_ready [3];
    logic [7:0] res_product [3];
    logic       err [3];
    logic       p_reset [3];
    logic       p_read [3];
    logic [3:0] p_nibble [3];
    logic [7:0] p_result [3];

    int vectors = 0;
    int miscompares = 0;
    int lat_of [3] = '{1, 3, 3};
    logic err_exp [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned DrvLat  = (g == 0) ? 1 : 3;
        localparam int unsigned UnitLat = (g == 1) ? 3 : 1;

        // Unit model: an 8-bit shift register that takes one nibble per edge.
        // A read replaces its contents with hi*lo.
        logic [7:0] acc;
        logic [7:0] pipe0, pipe1;

        always @(posedge clk) begin
            if (reset || p_reset[g]) begin
                acc   <= '0;
                pipe0 <= '0;
                pipe1 <= '0;
            end else begin
                if (p_read[g]) acc <= {4'b0, acc[7:4]} * {4'b0, acc[3:0]};
                else           acc <= {acc[3:0], p_nibble[g]};
                pipe0 <= acc;
                pipe1 <= pipe0;
            end
        end

        assign p_result[g] = (UnitLat == 1) ? acc : pipe1;

        anton_product_driver #(
            .LAT   (DrvLat),
            .CHECK (1'b1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_a       (req_a[g]),
            .req_b       (req_b[g]),
            .res_valid   (res_valid[g]),
            .res_ready   (res_ready[g]),
            .res_product (res_product[g]),
            .err         (err[g]),
            .p_reset     (p_reset[g]),
            .p_read      (p_read[g]),
            .p_nibble    (p_nibble[g]),
            .p_result    (p_result[g])
        );
    end

    task automatic check_eq(input string tag, input int lane, input logic [31:0] got,
                            input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", tag, lane, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int l = 0; l < 3; l++) req_valid[l] = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check_eq("rst_p_reset", l, p_reset[l], 0);
            check_eq("rst_res_valid", l, res_valid[l], 0);
            check_eq("rst_err", l, err[l], 0);
            check_eq("rst_p_read", l, p_read[l], 0);
            check_eq("rst_p_nibble", l, p_nibble[l], 0);
            check_eq("rst_req_ready", l, req_ready[l], 0);
            err_exp[l] = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check_eq("init_pulse", l, p_reset[l], 1);
            check_eq("init_req_ready", l, req_ready[l], 0);
            check_eq("init_res_valid", l, res_valid[l], 0);
        end
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check_eq("init_pulse_end", l, p_reset[l], 0);
            check_eq("idle_req_ready", l, req_ready[l], 1);
            check_eq("idle_res_valid", l, res_valid[l], 0);
        end
    endtask

    // One request/response transaction. hold > 0 stalls the response for that
    // many cycles while new requests are offered.
    task automatic txn(input int lane, input logic [3:0] a, input logic [3:0] b, input int hold);
        int n;
        logic [7:0] ref_p;
        logic [7:0] exp_p;
        ref_p = 8'(int'(a) * int'(b));
        // Lane 2 samples the unit two shifts of zeros after the product, which
        // leaves the register at zero.
        exp_p = (lane == 2) ? 8'd0 : ref_p;
        check_eq("pre_req_ready", lane, req_ready[lane], 1);
        req_valid[lane] = 1'b1;
        req_a[lane] = a;
        req_b[lane] = b;
        res_ready[lane] = (hold == 0);
        @(negedge clk);
        n = 1;
        req_valid[lane] = (hold > 0);
        req_a[lane] = 4'($urandom);
        req_b[lane] = 4'($urandom);
        check_eq("nib_a", lane, p_nibble[lane], a);
        check_eq("read_a", lane, p_read[lane], 0);
        check_eq("busy_ready", lane, req_ready[lane], 0);
        @(negedge clk);
        n++;
        check_eq("nib_b", lane, p_nibble[lane], b);
        check_eq("read_b", lane, p_read[lane], 0);
        @(negedge clk);
        n++;
        check_eq("read_pulse", lane, p_read[lane], 1);
        check_eq("read_nib", lane, p_nibble[lane], 0);
        while (!res_valid[lane] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_p != ref_p) err_exp[lane] = 1'b1;
        check_eq("latency", lane, n, 4 + lat_of[lane]);
        check_eq("product", lane, res_product[lane], exp_p);
        check_eq("err", lane, err[lane], err_exp[lane]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_a[lane] = 4'($urandom);
            req_b[lane] = 4'($urandom);
            check_eq("hold_valid", lane, res_valid[lane], 1);
            check_eq("hold_product", lane, res_product[lane], exp_p);
            check_eq("hold_req_ready", lane, req_ready[lane], 0);
        end
        res_ready[lane] = 1'b1;
        @(negedge clk);
        req_valid[lane] = 1'b0;
        check_eq("post_valid", lane, res_valid[lane], 0);
        check_eq("post_req_ready", lane, req_ready[lane], 1);
        check_eq("post_err", lane, err[lane], err_exp[lane]);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int l = 0; l < 3; l++) begin
            req_valid[l] = 1'b0;
            req_a[l]     = '0;
            req_b[l]     = '0;
            res_ready[l] = 1'b1;
            err_exp[l]   = 1'b0;
        end
        do_reset();

        txn(0, 4'd3, 4'd5, 0);
        txn(0, 4'd15, 4'd15, 0);
        txn(0, 4'd0, 4'd9, 0);
        txn(0, 4'd1, 4'd1, 1);
        txn(1, 4'd7, 4'd6, 0);
        txn(2, 4'd7, 4'd6, 0);
        txn(2, 4'd3, 4'd3, 2);
        txn(0, 4'd4, 4'd11, 10);

        repeat (20) begin
            txn($urandom_range(0, 1), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        // Abort a transaction in SEND_B with a reset.
        req_valid[0] = 1'b1;
        req_a[0] = 4'd9;
        req_b[0] = 4'd9;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check_eq("abort_nib_a", 0, p_nibble[0], 9);
        @(negedge clk);
        check_eq("abort_nib_b", 0, p_nibble[0], 9);
        do_reset();
        txn(0, 4'd2, 4'd4, 0);
        txn(1, 4'd12, 4'd13, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
